render_cmd_sequencer: RTL and testbench

Upstream command front-end for the `render` Avalon-MM slave. Accepts whole draw commands (background fill or sprite plot) on a valid/ready stream, buffers them in a small FIFO, and expands each into the ordered register-write sequence `render` expects (texture, X, Y, plot). It obeys `slave_waitrequest` on every transfer. It replaces hand-written per-command write FSMs in test and top-level logic.

---
 rtl/render_cmd_sequencer_pkg.sv | 23 ++
 rtl/render_cmd_sequencer_if.sv | 21 ++
 rtl/render_cmd_fifo.sv | 41 ++++
 rtl/render_cmd_sequencer.sv | 90 +++++++++
 tb/tb_render_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/render_cmd_sequencer_pkg.sv
// render_pkg: register map, screen limits, command type and sequencer states shared by render_cmd_sequencer
package render_pkg;
  localparam logic [3:0] RENDER_ADDR_X = 4'd1;
  localparam logic [3:0] RENDER_ADDR_Y = 4'd2;
  localparam logic [3:0] RENDER_ADDR_TEX = 4'd4;
  localparam logic [3:0] RENDER_ADDR_PLOT = 4'd6;
  localparam logic [8:0] SCREEN_W = 9'd320;
  localparam logic [7:0] SCREEN_H = 8'd240;
  typedef struct packed {
    logic bg;
    logic [6:0] tex;
    logic [8:0] x;
    logic [7:0] y;
  } render_cmd_t;
  typedef enum logic [2:0] {IDLE, POP, TEX, XW, YW, PLOT} state_t;
  function automatic logic [3:0] wr_addr(state_t s);
    return s == TEX ? RENDER_ADDR_TEX : s == XW ? RENDER_ADDR_X : s == YW ? RENDER_ADDR_Y :
           s == PLOT ? RENDER_ADDR_PLOT : 4'd0;
  endfunction
  function automatic logic [31:0] wr_data(state_t s, render_cmd_t c);
    return s == TEX ? {25'd0, c.tex} : s == XW ? {23'd0, c.x} : s == YW ? {24'd0, c.y} : 32'd0;
  endfunction
endpackage

// File: rtl/render_cmd_sequencer_if.sv
// render_cmd_sequencer_if: draw-command stream plus the Avalon-MM write bus towards render
interface render_cmd_sequencer_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_bg;
  logic [6:0] cmd_tex;
  logic [8:0] cmd_x;
  logic [7:0] cmd_y;
  logic [3:0] m_address;
  logic m_write;
  logic [31:0] m_writedata;
  logic m_waitrequest;
  modport master (
    output cmd_valid, cmd_bg, cmd_tex, cmd_x, cmd_y, m_waitrequest,
    input cmd_ready, m_address, m_write, m_writedata
  );
  modport slave (
    input cmd_valid, cmd_bg, cmd_tex, cmd_x, cmd_y, m_waitrequest,
    output cmd_ready, m_address, m_write, m_writedata
  );
endinterface

// File: rtl/render_cmd_fifo.sv
// render_cmd_fifo: small synchronous FIFO of draw commands with registered full flag
module render_cmd_fifo
  import render_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  render_cmd_t din,
  output render_cmd_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  render_cmd_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count_nxt;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign empty = count == '0;
  assign dout = mem[rp];
  // pointers, occupancy and full flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count_nxt;
      full <= count_nxt == CW'(DEPTH);
    end
  // command storage; contents are meaningless while empty so no reset
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
endmodule

// File: rtl/render_cmd_sequencer.sv
// render_cmd_sequencer: turns queued draw commands into render register writes; RENDER_SEQ_SKIP_REDUNDANT_EN skips writes the slave already holds
module render_cmd_sequencer
  import render_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  render_cmd_sequencer_if.slave bus,
  output logic busy,
  output logic [CNT_W-1:0] plot_count,
  output logic range_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, nxt;
  render_cmd_t din, head, work, cur;
  logic full, empty, push, pop, acc, bad, nt, nx, ny;
  logic [CW-1:0] count;
  assign din = {bus.cmd_bg, bus.cmd_tex, bus.cmd_x, bus.cmd_y};
  assign push = bus.cmd_valid & ~full;
  assign pop = state == POP;
  assign bus.cmd_ready = ~full;
  assign cur = pop ? head : work;
  assign bad = ~head.bg & ((head.x >= SCREEN_W) | (head.y >= SCREEN_H));
  assign acc = bus.m_write & ~bus.m_waitrequest;
  render_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
  logic tv, xv, yv;
  logic [6:0] ct;
  logic [8:0] cx;
  logic [7:0] cy;
  assign nt = ~(tv & (ct == cur.tex));
  assign nx = ~(xv & (cx == cur.x));
  assign ny = ~(yv & (cy == cur.y));
  // remember the last value the slave accepted at each data register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {tv, xv, yv} <= '0;
      ct <= '0;
      cx <= '0;
      cy <= '0;
    end else if (acc) begin
      if (state == TEX) begin tv <= 1'b1; ct <= work.tex; end
      if (state == XW) begin xv <= 1'b1; cx <= work.x; end
      if (state == YW) begin yv <= 1'b1; cy <= work.y; end
    end
`else
  assign nt = 1'b1;
  assign nx = 1'b1;
  assign ny = 1'b1;
`endif
  // next state; a write is held until accepted, redundant ones are jumped over
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = empty ? IDLE : POP;
      POP: nxt = bad ? IDLE : nt ? TEX : cur.bg ? PLOT : nx ? XW : ny ? YW : PLOT;
      TEX: nxt = !acc ? TEX : cur.bg ? PLOT : nx ? XW : ny ? YW : PLOT;
      XW: nxt = !acc ? XW : ny ? YW : PLOT;
      YW: nxt = acc ? PLOT : YW;
      PLOT: nxt = acc ? IDLE : PLOT;
      default: nxt = IDLE;
    endcase
  end
  // state, registered bus outputs and status flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      work <= '0;
      bus.m_write <= 1'b0;
      bus.m_address <= '0;
      bus.m_writedata <= '0;
      busy <= 1'b0;
      plot_count <= '0;
      range_err <= 1'b0;
    end else begin
      state <= nxt;
      if (pop) work <= head;
      bus.m_write <= nxt inside {TEX, XW, YW, PLOT};
      bus.m_address <= wr_addr(nxt);
      bus.m_writedata <= wr_data(nxt, cur);
      busy <= (nxt != IDLE) | push | (count > CW'(pop));
      if (state == PLOT && acc) plot_count <= plot_count + CNT_W'(1);
      if (pop && bad) range_err <= 1'b1;
    end
endmodule

// File: tb/tb_render_cmd_sequencer.sv
// tb_render_cmd_sequencer: directed self-checking bench for render_cmd_sequencer
module tb_render_cmd_sequencer;
  import render_pkg::*;
  localparam int CNT_W = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, range_err;
  logic [CNT_W-1:0] plot_count;
  int errors = 0, checks = 0, plots = 0, wr_cycles = 0;
  logic [35:0] wlog[$], exp_q[$];
  render_cmd_sequencer_if bus();
  render_cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy),
    .plot_count(plot_count), .range_err(range_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.m_write) wr_cycles++;
    if (bus.m_write && !bus.m_waitrequest) wlog.push_back({bus.m_address, bus.m_writedata});
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic exp_cmd(input logic bg, input logic [6:0] tex, input logic [8:0] x, input logic [7:0] y);
    exp_q.push_back({4'd4, 25'd0, tex});
    if (!bg) begin
      exp_q.push_back({4'd1, 23'd0, x});
      exp_q.push_back({4'd2, 24'd0, y});
    end
    exp_q.push_back({4'd6, 32'd0});
  endtask

  task automatic push_cmd(input logic bg, input logic [6:0] tex, input logic [8:0] x, input logic [7:0] y);
    int t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_bg = bg;
    bus.cmd_tex = tex;
    bus.cmd_x = x;
    bus.cmd_y = y;
    while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (t == 100) begin checks++; errors++; $display("FAIL push timeout ready=%b", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 300) begin @(negedge clk); cyc++; end
    if (busy) begin checks++; errors++; $display("FAIL idle timeout busy=%b", busy); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL reset m_write got %b want 0", bus.m_write); end
    checks++; if (bus.m_address !== 4'd0) begin errors++; $display("FAIL reset m_address got %h want 0", bus.m_address); end
    checks++; if (bus.m_writedata !== 32'd0) begin errors++; $display("FAIL reset m_writedata got %h want 0", bus.m_writedata); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got %b want 1", bus.cmd_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (plot_count !== '0) begin errors++; $display("FAIL reset plot_count got %0d want 0", plot_count); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset range_err got %b want 0", range_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_background;
    int cyc;
    wlog.delete(); exp_q.delete();
    exp_cmd(1'b1, 7'h3C, 9'd0, 8'd0);
    push_cmd(1'b1, 7'h3C, 9'd400, 8'd250);
    checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL bg m_write at N got %b want 0", bus.m_write); end
    @(negedge clk);
    checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL bg m_write at N+1 got %b want 0", bus.m_write); end
    @(negedge clk);
    checks++; if ({bus.m_write, bus.m_address, bus.m_writedata} !== {1'b1, 4'd4, 32'h3C})
      begin errors++; $display("FAIL bg first write at N+2 got %b/%h/%h want 1/4/3c", bus.m_write, bus.m_address, bus.m_writedata); end
    wait_idle(cyc);
    plots++;
    checks++; if (cyc + 2 != 4) begin errors++; $display("FAIL bg cycles got %0d want 4", cyc + 2); end
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL bg plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL bg range_err got %b want 0", range_err); end
    checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL bg log size got %0d want %0d", wlog.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp_q[i]) begin errors++; $display("FAIL bg write %0d got %h want %h", i, wlog.size() > i ? wlog[i] : 36'h0, exp_q[i]); end
    end
  endtask

  task automatic test_sprite_stall;
    int cyc = 0, stalls = 0;
    logic held = 1'b0;
    wlog.delete(); exp_q.delete();
    exp_cmd(1'b0, 7'd5, 9'd159, 8'd119);
    push_cmd(1'b0, 7'd5, 9'd159, 8'd119);
    while (busy && cyc < 100) begin
      if (held) begin
        checks++;
        if ({bus.m_write, bus.m_address, bus.m_writedata} !== {1'b1, 4'd1, 32'd159})
          begin errors++; $display("FAIL stall hold got %b/%h/%h want 1/1/9f", bus.m_write, bus.m_address, bus.m_writedata); end
      end
      held = bus.m_write && bus.m_address == 4'd1 && stalls < 3;
      bus.m_waitrequest = held;
      if (held) stalls++;
      @(negedge clk);
      cyc++;
    end
    bus.m_waitrequest = 1'b0;
    plots++;
    checks++; if (cyc != 9) begin errors++; $display("FAIL stall cycles got %0d want 9", cyc); end
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL stall plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL stall log size got %0d want %0d", wlog.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp_q[i]) begin errors++; $display("FAIL stall write %0d got %h want %h", i, wlog.size() > i ? wlog[i] : 36'h0, exp_q[i]); end
    end
  endtask

  task automatic test_range;
    int cyc, w0;
    wlog.delete(); exp_q.delete();
    w0 = wr_cycles;
    push_cmd(1'b0, 7'd3, 9'd320, 8'd10);
    wait_idle(cyc);
    checks++; if (cyc != 2) begin errors++; $display("FAIL range x cycles got %0d want 2", cyc); end
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range x range_err got %b want 1", range_err); end
    push_cmd(1'b0, 7'd3, 9'd0, 8'd240);
    wait_idle(cyc);
    checks++; if (wr_cycles != w0) begin errors++; $display("FAIL range m_write cycles got %0d want 0", wr_cycles - w0); end
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL range plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    exp_cmd(1'b0, 7'd1, 9'd319, 8'd239);
    push_cmd(1'b0, 7'd1, 9'd319, 8'd239);
    wait_idle(cyc);
    plots++;
    checks++; if (cyc != 6) begin errors++; $display("FAIL range edge cycles got %0d want 6", cyc); end
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL range edge plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range sticky got %b want 1", range_err); end
    checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL range log size got %0d want %0d", wlog.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp_q[i]) begin errors++; $display("FAIL range write %0d got %h want %h", i, wlog.size() > i ? wlog[i] : 36'h0, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back;
    logic bg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0] tx [6] = '{7'd9, 7'd10, 7'd13, 7'd14, 7'd17, 7'd20};
    logic [8:0] xs [6] = '{9'd0, 9'd11, 9'd0, 9'd15, 9'd18, 9'd0};
    logic [7:0] ys [6] = '{8'd0, 8'd12, 8'd0, 8'd16, 8'd19, 8'd0};
    int cyc, t = 0;
    wlog.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) exp_cmd(bg[i], tx[i], xs[i], ys[i]);
    bus.m_waitrequest = 1'b1;
    push_cmd(bg[0], tx[0], xs[0], ys[0]);
    repeat (3) @(negedge clk);
    checks++; if ({bus.m_write, bus.m_address} !== {1'b1, 4'd4}) begin errors++; $display("FAIL b2b parked got %b/%h want 1/4", bus.m_write, bus.m_address); end
    for (int i = 1; i < 5; i++) push_cmd(bg[i], tx[i], xs[i], ys[i]);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b ready after 4 got %b want 0", bus.cmd_ready); end
    bus.cmd_valid = 1'b1;
    bus.cmd_bg = bg[5]; bus.cmd_tex = tx[5]; bus.cmd_x = xs[5]; bus.cmd_y = ys[5];
    repeat (3) begin
      @(negedge clk);
      checks++; if (bus.cmd_ready !== 1'b0 || wlog.size() != 0) begin errors++; $display("FAIL b2b full hold ready=%b writes=%0d want 0/0", bus.cmd_ready, wlog.size()); end
    end
    bus.m_waitrequest = 1'b0;
    while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b ready after release got %b want 1", bus.cmd_ready); end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_idle(cyc);
    plots += 6;
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL b2b plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL b2b log size got %0d want %0d", wlog.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp_q[i]) begin errors++; $display("FAIL b2b write %0d got %h want %h", i, wlog.size() > i ? wlog[i] : 36'h0, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int t = 0, w0, n0;
    push_cmd(1'b0, 7'd2, 9'd4, 8'd6);
    push_cmd(1'b1, 7'd8, 9'd0, 8'd0);
    while (!(bus.m_write && bus.m_address == 4'd2) && t < 50) begin @(negedge clk); t++; end
    checks++; if ({bus.m_write, bus.m_address} !== {1'b1, 4'd2}) begin errors++; $display("FAIL rst reach YW got %b/%h want 1/2", bus.m_write, bus.m_address); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.m_write !== 1'b0) begin errors++; $display("FAIL rst m_write got %b want 0", bus.m_write); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst busy got %b want 0", busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst cmd_ready got %b want 1", bus.cmd_ready); end
    checks++; if (plot_count !== '0 || range_err !== 1'b0) begin errors++; $display("FAIL rst status got %0d/%b want 0/0", plot_count, range_err); end
    @(negedge clk);
    rst_n = 1'b1;
    plots = 0;
    w0 = wr_cycles;
    n0 = wlog.size();
    repeat (6) @(negedge clk);
    checks++; if (wr_cycles != w0 || wlog.size() != n0 || busy !== 1'b0)
      begin errors++; $display("FAIL rst fifo empty m_write cycles=%0d busy=%b want 0/0", wr_cycles - w0, busy); end
  endtask

  task automatic test_skip_redundant;
    int cyc;
    wlog.delete(); exp_q.delete();
    exp_cmd(1'b0, 7'd7, 9'd10, 8'd20);
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
    exp_q.push_back({4'd6, 32'd0});
`else
    exp_cmd(1'b0, 7'd7, 9'd10, 8'd20);
`endif
    push_cmd(1'b0, 7'd7, 9'd10, 8'd20);
    wait_idle(cyc);
    checks++; if (cyc != 6) begin errors++; $display("FAIL skip first cycles got %0d want 6", cyc); end
    push_cmd(1'b0, 7'd7, 9'd10, 8'd20);
    wait_idle(cyc);
`ifdef RENDER_SEQ_SKIP_REDUNDANT_EN
    checks++; if (cyc != 3) begin errors++; $display("FAIL skip second cycles got %0d want 3", cyc); end
`else
    checks++; if (cyc != 6) begin errors++; $display("FAIL skip second cycles got %0d want 6", cyc); end
`endif
    plots += 2;
    checks++; if (plot_count !== CNT_W'(plots)) begin errors++; $display("FAIL skip plot_count got %0d want %0d", plot_count, CNT_W'(plots)); end
    checks++; if (wlog.size() != exp_q.size()) begin errors++; $display("FAIL skip log size got %0d want %0d", wlog.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (wlog.size() <= i || wlog[i] !== exp_q[i]) begin errors++; $display("FAIL skip write %0d got %h want %h", i, wlog.size() > i ? wlog[i] : 36'h0, exp_q[i]); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_bg = 1'b0;
    bus.cmd_tex = '0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.m_waitrequest = 1'b0;
    test_reset();
    test_background();
    test_sprite_stall();
    test_range();
    test_back_to_back();
    test_reset_mid();
    test_skip_redundant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
